// File: rtl/dds_phase_gen.sv
// Phase-accumulator DDS front end: quarter-wave ROM addressing, sign restoration and a
// phase-continuous tuning-word handshake that swaps words only on accumulator wrap.
module dds_phase_gen #(
    parameter int unsigned PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    output logic [8:0]         rom_adrs,
    input  logic [15:0]        rom_data,
    output logic [16:0]        outsine,
    output logic               out_valid,
    output logic               wrap
);

    typedef enum logic {StIdle, StPend} state_e;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_act_q, ftw_act_d;
    logic [PHASE_W-1:0] ftw_pend_q, ftw_pend_d;
    logic               ftw_ready_q, ftw_ready_d;
    logic               wrap_q, wrap_d;
    logic               sign_q, sign_d;
    logic [8:0]         rom_adrs_q, rom_adrs_d;
    logic [16:0]        outsine_q, outsine_d;
    logic [1:0]         valid_q, valid_d;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic [1:0]         quad;
    logic [8:0]         idx;

    // Accumulator and wrap detection
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, ftw_act_q};
        carry  = en & ~phase_clr & sum[PHASE_W];
        wrap_d = carry;
        acc_d  = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[PHASE_W-1:0];
        end
    end

    // Tuning-word handshake; ready_q is low for the first cycle out of reset
    always_comb begin
        state_d    = state_q;
        ftw_pend_d = ftw_pend_q;
        ftw_act_d  = ftw_act_q;
        unique case (state_q)
            StIdle: begin
                if (ftw_ready_q && ftw_valid) begin
                    ftw_pend_d = ftw;
                    state_d    = StPend;
                end
            end
            StPend: begin
                if (carry || !en || phase_clr) begin
                    ftw_act_d = ftw_pend_q;
                    state_d   = StIdle;
                end
            end
        endcase
        ftw_ready_d = (state_d == StIdle);
    end

    // Two-stage output pipeline, frozen while en is low
    always_comb begin
        quad       = acc_q[PHASE_W-1 -: 2];
        idx        = acc_q[PHASE_W-3 -: 9];
        rom_adrs_d = rom_adrs_q;
        sign_d     = sign_q;
        outsine_d  = outsine_q;
        if (en) begin
            rom_adrs_d = quad[0] ? ~idx : idx;
            sign_d     = quad[1];
            outsine_d  = sign_q ? -{1'b0, rom_data} : {1'b0, rom_data};
        end
        valid_d = {valid_q[0], en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ftw_act_q   <= '0;
            ftw_pend_q  <= '0;
            ftw_ready_q <= 1'b0;
            wrap_q      <= 1'b0;
            sign_q      <= 1'b0;
            rom_adrs_q  <= '0;
            outsine_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_act_q   <= ftw_act_d;
            ftw_pend_q  <= ftw_pend_d;
            ftw_ready_q <= ftw_ready_d;
            wrap_q      <= wrap_d;
            sign_q      <= sign_d;
            rom_adrs_q  <= rom_adrs_d;
            outsine_q   <= outsine_d;
            valid_q     <= valid_d;
        end
    end

    assign ftw_ready = ftw_ready_q;
    assign rom_adrs  = rom_adrs_q;
    assign outsine   = outsine_q;
    assign wrap      = wrap_q;
    assign out_valid = valid_q[1] & en;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: directed scenarios plus random traffic, all outputs compared
// every cycle against an arithmetic reference model.
module tb_dds_phase_gen;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          phase_clr = 1'b0;
    logic [W-1:0]  ftw = '0;
    logic          ftw_valid = 1'b0;
    logic          ftw_ready;
    logic [8:0]    rom_adrs;
    logic [15:0]   rom_data;
    logic [16:0]   outsine;
    logic          out_valid;
    logic          wrap;

    logic [15:0]   rom_mem [512];
    assign rom_data = rom_mem[rom_adrs];

    dds_phase_gen #(.PHASE_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_clr (phase_clr),
        .ftw       (ftw),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .rom_adrs  (rom_adrs),
        .rom_data  (rom_data),
        .outsine   (outsine),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state (plain integers, W-bit phase held in 64-bit words)
    localparam logic [63:0] Mask = (64'd1 << W) - 64'd1;
    logic [63:0] m_acc, m_act, m_pend;
    bit          m_pending, m_ready, m_wrap, m_neg, m_en_d0, m_en_d1;
    int          m_adrs, m_out;

    function automatic int adrs_of(input logic [63:0] a);
        int quad, idx;
        quad = int'(a >> (W - 2));
        idx  = int'((a >> (W - 11)) % 512);
        return (quad % 2 == 1) ? 511 - idx : idx;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_act = 0; m_pend = 0;
        m_pending = 0; m_ready = 0; m_wrap = 0; m_neg = 0;
        m_en_d0 = 0; m_en_d1 = 0; m_adrs = 0; m_out = 0;
    endtask

    task automatic model_edge();
        logic [63:0] sum;
        bit c;
        sum    = m_acc + m_act;
        c      = en && !phase_clr && ((sum >> W) != 0);
        m_wrap = c;
        if (en) begin
            m_out  = m_neg ? -int'(rom_mem[m_adrs]) : int'(rom_mem[m_adrs]);
            m_neg  = ((m_acc >> (W - 1)) & 64'd1) != 0;
            m_adrs = adrs_of(m_acc);
        end
        if (phase_clr)  m_acc = 0;
        else if (en)    m_acc = sum & Mask;
        if (m_pending) begin
            if (c || !en || phase_clr) begin
                m_act     = m_pend;
                m_pending = 0;
            end
        end else if (m_ready && ftw_valid) begin
            m_pend    = 64'(ftw);
            m_pending = 1;
        end
        m_ready = !m_pending;
        m_en_d1 = m_en_d0;
        m_en_d0 = en;
    endtask

    task automatic check_all();
        logic [16:0] exp_out;
        exp_out = 17'(m_out);
        check("rom_adrs", 64'(rom_adrs), 64'(m_adrs));
        check("outsine", 64'(outsine), 64'(exp_out));
        check("out_valid", 64'(out_valid), 64'(m_en_d1 && en));
        check("wrap", 64'(wrap), 64'(m_wrap));
        check("ftw_ready", 64'(ftw_ready), 64'(m_ready));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ftw_ready), 64'd0);
        check({tag, "_adrs"}, 64'(rom_adrs), 64'd0);
        check({tag, "_out"}, 64'(outsine), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_wrap"}, 64'(wrap), 64'd0);
    endtask

    // Loads a word with en low so it is applied on the edge after capture
    task automatic load_word(input logic [W-1:0] w);
        int g;
        en = 1'b0;
        g  = 0;
        while (!ftw_ready && g < 20) begin
            cycle();
            g++;
        end
        check("load_ready", 64'(ftw_ready), 64'd1);
        ftw = w; ftw_valid = 1'b1;
        cycle();
        ftw_valid = 1'b0;
        cycle();
    endtask

    initial begin
        int g;
        for (int i = 0; i < 512; i++) rom_mem[i] = 16'($urandom);
        rom_mem[5] = 16'd1000;
        model_reset();

        #1 check_reset_outputs("rst_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Handshake with en low, then a full quadrant 0/1 address ramp
        ftw = 32'h0020_0000; ftw_valid = 1'b1;
        cycle(); check("hs_ready1", 64'(ftw_ready), 64'd1);
        cycle(); check("hs_ready2", 64'(ftw_ready), 64'd0);
        ftw_valid = 1'b0;
        cycle(); check("hs_ready3", 64'(ftw_ready), 64'd1);
        en = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            cycle();
            check("ramp", 64'(rom_adrs), 64'((k < 512) ? k : 1023 - k));
        end

        // Wrap from 0xFFFF_FFF0 by 0x20
        en = 1'b0; phase_clr = 1'b1; cycle(); phase_clr = 1'b0;
        load_word(32'hFFFF_FFF0);
        en = 1'b1; cycle();
        load_word(32'h0000_0020);
        en = 1'b1; cycle();
        check("wrap_pulse", 64'(wrap), 64'd1);
        check("acc_after_wrap", 64'(dut.acc_q), 64'h10);
        cycle();
        check("wrap_single", 64'(wrap), 64'd0);

        // Quadrant 2, idx 5 -> -1000 two edges later
        en = 1'b0; phase_clr = 1'b1; cycle(); phase_clr = 1'b0;
        load_word(32'h8000_0000 + (32'd5 << 21));
        en = 1'b1;
        cycle();
        cycle(); check("q2_adrs", 64'(rom_adrs), 64'd5);
        cycle();
        check("neg1000", 64'(outsine), 64'h1FC18);
        check("neg_valid", 64'(out_valid), 64'd1);

        // Phase-continuous swap on wrap; offers during pending are ignored
        en = 1'b0; phase_clr = 1'b1; cycle(); phase_clr = 1'b0;
        load_word(32'h4000_0000);
        en = 1'b1; cycle(); cycle();
        ftw = 32'h2000_0000; ftw_valid = 1'b1;
        cycle();
        check("pend_ready0", 64'(ftw_ready), 64'd0);
        ftw = 32'h0000_1234;
        g = 0;
        while (g < 8) begin
            cycle();
            g++;
            if (wrap) break;
            check("pend_ready", 64'(ftw_ready), 64'd0);
        end
        ftw_valid = 1'b0;
        check("swap_wrap", 64'(wrap), 64'd1);
        check("swap_ready", 64'(ftw_ready), 64'd1);
        cycle();
        check("new_inc", 64'(dut.acc_q), 64'h2000_0000);

        // phase_clr coinciding with a carry while a word is pending
        ftw = 32'h0100_0000; ftw_valid = 1'b1;
        cycle();
        ftw_valid = 1'b0;
        g = 0;
        while (((m_acc + m_act) >> W) == 0 && g < 16) begin
            cycle();
            g++;
        end
        phase_clr = 1'b1;
        cycle();
        phase_clr = 1'b0;
        check("clr_wrap", 64'(wrap), 64'd0);
        check("clr_ready", 64'(ftw_ready), 64'd1);
        check("clr_acc", 64'(dut.acc_q), 64'd0);
        cycle();
        check("clr_inc", 64'(dut.acc_q), 64'h0100_0000);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            en        = ($urandom_range(0, 9) != 0);
            phase_clr = ($urandom_range(0, 49) == 0);
            ftw_valid = ($urandom_range(0, 3) == 0);
            ftw       = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4095)) : W'($urandom);
            cycle();
        end

        // Asynchronous reset mid-stream
        en = 1'b1; phase_clr = 1'b0; ftw_valid = 1'b0;
        repeat (3) cycle();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();
        check("post_rst_ready", 64'(ftw_ready), 64'd1);
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
